axi4_lite_master_read_timeout_monitor: RTL and testbench

AXI4_LITE_MASTER_READ_TIMEOUT_MONITOR -- requirements
Module: axi4_lite_master_read_timeout_monitor

---
 rtl/axi4_lite_master_read_timeout_monitor_if.sv | 30 +++
 rtl/axi4_lite_master_read_timeout_monitor.sv | 234 +++++++++++++++++++++++
 tb/tb_axi4_lite_master_read_timeout_monitor.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_master_read_timeout_monitor_if.sv
// rtl/axi4_lite_master_read_timeout_monitor_if.sv - AXI4-Lite read address/data channel bundle
interface axi4_lite_master_read_timeout_monitor_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    modport master (
        output arvalid, araddr, arprot, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, arprot, rready,
        output arready, rvalid, rdata, rresp
    );

    // Passive observer: every channel signal is an input
    modport monitor (
        input arvalid, arready, araddr, arprot,
        input rvalid, rready, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_master_read_timeout_monitor.sv
// rtl/axi4_lite_master_read_timeout_monitor.sv - passive AXI4-Lite read timeout/protocol monitor
// Optional coverage counters enabled by AXI4LITE_MASTER_READ_MON_COVER_EN.
module axi4_lite_master_read_timeout_monitor #(
    parameter int ADDR_WIDTH                = 32,
    parameter int DATA_WIDTH                = 32,
    parameter int MAX_DELAY_ARREADY         = 16,
    parameter int MAX_DELAY_RVALID          = 10,
    parameter int MAX_DELAY_RREADY          = 16,
    parameter int MAX_OUTSTANDING           = 4,
    parameter int DELAY_FOR_SECOND_TRANSFER = 16
) (
    input  logic                                     aclk,
    input  logic                                     aresetn,
    axi4_lite_master_read_timeout_monitor_if.monitor axi,
    input  logic                                     clear,
    output logic [6:0]                               err_flags,
    output logic                                     err_valid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
    output logic [15:0]                              txn_count,
    output logic [15:0]                              b2b_count,
    output logic [7:0]                               max_rvalid_latency
);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int ARW = $clog2(MAX_DELAY_ARREADY + 1);
    localparam int RVW = $clog2(MAX_DELAY_RVALID + 1);
    localparam int RRW = $clog2(MAX_DELAY_RREADY + 1);

    localparam logic [OW-1:0]  OUT_MAX     = OW'(MAX_OUTSTANDING);
    localparam logic [ARW-1:0] AR_LIM      = ARW'(MAX_DELAY_ARREADY);
    localparam logic [ARW-1:0] AR_LIM_M1   = ARW'(MAX_DELAY_ARREADY - 1);
    localparam logic [RVW-1:0] RV_LIM      = RVW'(MAX_DELAY_RVALID);
    localparam logic [RVW-1:0] RV_LIM_M1   = RVW'(MAX_DELAY_RVALID - 1);
    localparam logic [RRW-1:0] RR_LIM      = RRW'(MAX_DELAY_RREADY);
    localparam logic [RRW-1:0] RR_LIM_M1   = RRW'(MAX_DELAY_RREADY - 1);

    logic ar_hs, ar_stall, r_hs, r_stall;

    assign ar_hs    = axi.arvalid && axi.arready;
    assign ar_stall = axi.arvalid && !axi.arready;
    assign r_hs     = axi.rvalid && axi.rready;
    assign r_stall  = axi.rvalid && !axi.rready;

    logic [ARW-1:0] ar_stall_cnt;
    logic [RVW-1:0] rvalid_wait_cnt;
    logic [RRW-1:0] r_stall_cnt;

    // Stall counters saturate at their limit so each stall reports only once
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_stall_cnt <= '0;
        end else if (ar_stall) begin
            if (ar_stall_cnt != AR_LIM) ar_stall_cnt <= ar_stall_cnt + 1'b1;
        end else begin
            ar_stall_cnt <= '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_wait_cnt <= '0;
        end else if (r_hs || outstanding == '0) begin
            rvalid_wait_cnt <= '0;
        end else if (!axi.rvalid && rvalid_wait_cnt != RV_LIM) begin
            rvalid_wait_cnt <= rvalid_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_stall_cnt <= '0;
        end else if (r_stall) begin
            if (r_stall_cnt != RR_LIM) r_stall_cnt <= r_stall_cnt + 1'b1;
        end else begin
            r_stall_cnt <= '0;
        end
    end

    logic                  ar_stall_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [2:0]            arprot_q;
    logic                  r_stall_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    // Payload snapshot of a stalled beat, compared against the following cycle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_stall_q <= 1'b0;
            araddr_q   <= '0;
            arprot_q   <= '0;
            r_stall_q  <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
        end else begin
            ar_stall_q <= ar_stall;
            r_stall_q  <= r_stall;
            if (ar_stall) begin
                araddr_q <= axi.araddr;
                arprot_q <= axi.arprot;
            end
            if (r_stall) begin
                rdata_q <= axi.rdata;
                rresp_q <= axi.rresp;
            end
        end
    end

    logic [OW-1:0] outstanding_next;
    logic          unexpected_r;
    logic          overflow_ar;

    always_comb begin
        outstanding_next = outstanding;
        unexpected_r     = 1'b0;
        overflow_ar      = 1'b0;
        if (ar_hs && !r_hs) begin
            if (outstanding == OUT_MAX) overflow_ar      = 1'b1;
            else                        outstanding_next = outstanding + 1'b1;
        end else if (r_hs && !ar_hs) begin
            if (outstanding == '0) unexpected_r     = 1'b1;
            else                   outstanding_next = outstanding - 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) outstanding <= '0;
        else          outstanding <= outstanding_next;
    end

    logic [6:0] err_set;

    always_comb begin
        err_set    = '0;
        err_set[0] = ar_stall && (ar_stall_cnt == AR_LIM_M1);
        err_set[1] = (outstanding != '0) && !axi.rvalid && (rvalid_wait_cnt == RV_LIM_M1);
        err_set[2] = r_stall && (r_stall_cnt == RR_LIM_M1);
        err_set[3] = ar_stall_q && (!axi.arvalid || axi.araddr != araddr_q || axi.arprot != arprot_q);
        err_set[4] = r_stall_q && (!axi.rvalid || axi.rdata != rdata_q || axi.rresp != rresp_q);
        err_set[5] = unexpected_r;
        err_set[6] = overflow_ar;
    end

    // clear takes priority over any error raised in the same cycle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_flags <= '0;
            err_valid <= 1'b0;
        end else if (clear) begin
            err_flags <= '0;
            err_valid <= 1'b0;
        end else begin
            err_flags <= err_flags | err_set;
            err_valid <= |(err_set & ~err_flags);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)  txn_count <= '0;
        else if (clear) txn_count <= '0;
        else if (r_hs)  txn_count <= txn_count + 16'd1;
    end

`ifdef AXI4LITE_MASTER_READ_MON_COVER_EN
    localparam int SW = $clog2(DELAY_FOR_SECOND_TRANSFER + 2);
    localparam logic [SW-1:0] B2B_WIN = SW'(DELAY_FOR_SECOND_TRANSFER);
    localparam logic [SW-1:0] B2B_SAT = SW'(DELAY_FOR_SECOND_TRANSFER + 1);

    // Cycles since the previous AR handshake; stays 0 until the first one after reset
    logic [SW-1:0] since_ar;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            since_ar <= '0;
        end else if (ar_hs) begin
            since_ar <= SW'(1);
        end else if (since_ar != '0 && since_ar != B2B_SAT) begin
            since_ar <= since_ar + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            b2b_count <= '0;
        end else if (clear) begin
            b2b_count <= '0;
        end else if (ar_hs && since_ar != '0 && since_ar <= B2B_WIN && b2b_count != 16'hFFFF) begin
            b2b_count <= b2b_count + 16'd1;
        end
    end

    // Per-read age queue in issue order; head is the oldest outstanding read
    logic [7:0]    ages      [MAX_OUTSTANDING];
    logic [7:0]    ages_next [MAX_OUTSTANDING];
    logic [7:0]    shifted   [MAX_OUTSTANDING];
    logic          lat_pop;
    logic          lat_push;
    logic [OW-1:0] wr_idx;

    always_comb begin
        lat_pop  = r_hs && (outstanding != '0);
        lat_push = ar_hs && (lat_pop || (!r_hs && outstanding != OUT_MAX));
        wr_idx   = lat_pop ? outstanding - 1'b1 : outstanding;
        for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
            shifted[i] = lat_pop ? ages[i+1] : ages[i];
        end
        shifted[MAX_OUTSTANDING-1] = lat_pop ? 8'd0 : ages[MAX_OUTSTANDING-1];
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            ages_next[i] = (shifted[i] != 8'hFF) ? shifted[i] + 8'd1 : shifted[i];
            if (lat_push && OW'(i) == wr_idx) ages_next[i] = 8'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) ages[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) ages[i] <= ages_next[i];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            max_rvalid_latency <= '0;
        end else if (clear) begin
            max_rvalid_latency <= '0;
        end else if (lat_pop && ages[0] > max_rvalid_latency) begin
            max_rvalid_latency <= ages[0];
        end
    end
`else
    assign b2b_count          = '0;
    assign max_rvalid_latency = '0;
`endif
endmodule

// File: tb/tb_axi4_lite_master_read_timeout_monitor.sv
// tb/tb_axi4_lite_master_read_timeout_monitor.sv - scoreboard bench for the read timeout monitor
module tb_axi4_lite_master_read_timeout_monitor;
    localparam int AW = 32;
    localparam int DW = 32;

`ifdef AXI4LITE_MASTER_READ_MON_COVER_EN
    localparam bit COV = 1'b1;
`else
    localparam bit COV = 1'b0;
`endif

    localparam int S_FLAGS = 0, S_VALID = 1, S_OUT = 2, S_TXN = 3, S_B2B = 4, S_LAT = 5, S_PULSES = 6;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        clear = 1'b0;
    logic [6:0]  err_flags;
    logic        err_valid;
    logic [2:0]  outstanding;
    logic [15:0] txn_count;
    logic [15:0] b2b_count;
    logic [7:0]  max_rvalid_latency;

    axi4_lite_master_read_timeout_monitor_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_master_read_timeout_monitor dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .axi                (bus),
        .clear              (clear),
        .err_flags          (err_flags),
        .err_valid          (err_valid),
        .outstanding        (outstanding),
        .txn_count          (txn_count),
        .b2b_count          (b2b_count),
        .max_rvalid_latency (max_rvalid_latency)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_FLAGS:  return 32'(err_flags);
            S_VALID:  return 32'(err_valid);
            S_OUT:    return 32'(outstanding);
            S_TXN:    return 32'(txn_count);
            S_B2B:    return 32'(b2b_count);
            S_LAT:    return 32'(max_rvalid_latency);
            default:  return 32'(pulses);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic score();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        if (err_valid) pulses++;
    endtask

    task automatic idle_bus();
        bus.arvalid = 1'b0;
        bus.arready = 1'b0;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.rvalid  = 1'b0;
        bus.rready  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = '0;
        clear       = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        idle_bus();
        tick();
        tick();
        aresetn = 1'b1;
        pulses  = 0;
    endtask

    task automatic ar_hs_cycle();
        bus.arvalid = 1'b1;
        bus.arready = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        bus.arready = 1'b0;
    endtask

    task automatic r_hs_cycle();
        bus.rvalid = 1'b1;
        bus.rready = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        bus.rready = 1'b0;
    endtask

    initial begin
        idle_bus();
        tick();
        expect_val("rst_flags", S_FLAGS, 0);
        expect_val("rst_valid", S_VALID, 0);
        expect_val("rst_out", S_OUT, 0);
        expect_val("rst_txn", S_TXN, 0);
        expect_val("rst_b2b", S_B2B, 0);
        expect_val("rst_lat", S_LAT, 0);
        score();

        // AR stall timeout, single pulse
        do_reset();
        bus.arvalid = 1'b1;
        bus.araddr  = 32'h100;
        for (int i = 0; i < 15; i++) tick();
        expect_val("ar_stall15_flags", S_FLAGS, 0);
        score();
        tick();
        expect_val("ar_stall16_flags", S_FLAGS, 7'h01);
        expect_val("ar_stall16_valid", S_VALID, 1);
        score();
        for (int i = 0; i < 4; i++) tick();
        expect_val("ar_stall_pulses", S_PULSES, 1);
        score();
        bus.arready = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        bus.arready = 1'b0;
        expect_val("ar_stall_out", S_OUT, 1);
        score();
        r_hs_cycle();
        expect_val("ar_stall_end_flags", S_FLAGS, 7'h01);
        expect_val("ar_stall_end_out", S_OUT, 0);
        expect_val("ar_stall_end_txn", S_TXN, 1);
        score();

        // rvalid latency timeout
        do_reset();
        ar_hs_cycle();
        for (int i = 0; i < 9; i++) tick();
        expect_val("rlat9_flags", S_FLAGS, 0);
        score();
        tick();
        expect_val("rlat10_flags", S_FLAGS, 7'h02);
        score();

        // rvalid on time
        do_reset();
        ar_hs_cycle();
        expect_val("rok_out1", S_OUT, 1);
        score();
        tick();
        tick();
        r_hs_cycle();
        expect_val("rok_flags", S_FLAGS, 0);
        expect_val("rok_txn", S_TXN, 1);
        expect_val("rok_out0", S_OUT, 0);
        expect_val("rok_lat", S_LAT, COV ? 32'd3 : 32'd0);
        score();

        // araddr unstable during stall
        do_reset();
        bus.arvalid = 1'b1;
        bus.araddr  = 32'h100;
        tick();
        tick();
        expect_val("ar_stable_flags", S_FLAGS, 0);
        score();
        bus.araddr = 32'h104;
        tick();
        expect_val("ar_unstable_flags", S_FLAGS, 7'h08);
        score();

        // outstanding overflow then unexpected R
        do_reset();
        bus.arvalid = 1'b1;
        bus.arready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        expect_val("ovf4_out", S_OUT, 4);
        expect_val("ovf4_flags", S_FLAGS, 0);
        score();
        tick();
        bus.arvalid = 1'b0;
        bus.arready = 1'b0;
        expect_val("ovf5_out", S_OUT, 4);
        expect_val("ovf5_flags", S_FLAGS, 7'h40);
        score();
        bus.rvalid = 1'b1;
        bus.rready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        expect_val("drain_out", S_OUT, 0);
        expect_val("drain_flags", S_FLAGS, 7'h40);
        score();
        tick();
        bus.rvalid = 1'b0;
        bus.rready = 1'b0;
        expect_val("unexp_flags", S_FLAGS, 7'h60);
        expect_val("unexp_out", S_OUT, 0);
        expect_val("unexp_txn", S_TXN, 5);
        expect_val("ovf_b2b", S_B2B, COV ? 32'd4 : 32'd0);
        expect_val("ovf_lat", S_LAT, COV ? 32'd5 : 32'd0);
        score();

        // R stall timeout and rdata instability
        do_reset();
        ar_hs_cycle();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hA5;
        for (int i = 0; i < 15; i++) tick();
        expect_val("r_stall15_flags", S_FLAGS, 0);
        score();
        tick();
        expect_val("r_stall16_flags", S_FLAGS, 7'h04);
        score();
        bus.rdata = 32'h5A;
        tick();
        expect_val("r_unstable_flags", S_FLAGS, 7'h14);
        score();
        bus.rready = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        bus.rready = 1'b0;
        expect_val("r_stall_out", S_OUT, 0);
        expect_val("r_stall_txn", S_TXN, 1);
        expect_val("r_stall_pulses", S_PULSES, 2);
        score();

        // simultaneous AR/R handshake and clear
        do_reset();
        r_hs_cycle();
        expect_val("stray_flags", S_FLAGS, 7'h20);
        score();
        ar_hs_cycle();
        ar_hs_cycle();
        bus.arvalid = 1'b1;
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        bus.rready  = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        bus.arready = 1'b0;
        expect_val("both_out", S_OUT, 2);
        expect_val("both_txn", S_TXN, 2);
        score();
        tick();
        tick();
        bus.rvalid = 1'b0;
        bus.rready = 1'b0;
        expect_val("pre_clear_txn", S_TXN, 4);
        expect_val("pre_clear_out", S_OUT, 0);
        score();
        clear      = 1'b1;
        bus.rvalid = 1'b1;
        bus.rready = 1'b1;
        tick();
        clear      = 1'b0;
        bus.rvalid = 1'b0;
        bus.rready = 1'b0;
        expect_val("clear_flags", S_FLAGS, 0);
        expect_val("clear_txn", S_TXN, 0);
        expect_val("clear_valid", S_VALID, 0);
        expect_val("clear_out", S_OUT, 0);
        score();

        // back-to-back window: AR at cycles 0, 5, 30
        do_reset();
        ar_hs_cycle();
        r_hs_cycle();
        for (int i = 0; i < 3; i++) tick();
        ar_hs_cycle();
        r_hs_cycle();
        for (int i = 0; i < 23; i++) tick();
        ar_hs_cycle();
        r_hs_cycle();
        expect_val("b2b_count", S_B2B, COV ? 32'd1 : 32'd0);
        expect_val("b2b_lat", S_LAT, COV ? 32'd1 : 32'd0);
        expect_val("b2b_flags", S_FLAGS, 0);
        expect_val("b2b_txn", S_TXN, 3);
        score();

        // asynchronous reset mid-burst
        do_reset();
        ar_hs_cycle();
        ar_hs_cycle();
        r_hs_cycle();
        r_hs_cycle();
        r_hs_cycle();
        expect_val("pre_rst_flags", S_FLAGS, 7'h20);
        expect_val("pre_rst_txn", S_TXN, 3);
        score();
        ar_hs_cycle();
        bus.arvalid = 1'b1;
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        expect_val("async_flags", S_FLAGS, 0);
        expect_val("async_valid", S_VALID, 0);
        expect_val("async_out", S_OUT, 0);
        expect_val("async_txn", S_TXN, 0);
        expect_val("async_b2b", S_B2B, 0);
        expect_val("async_lat", S_LAT, 0);
        score();
        idle_bus();
        tick();
        aresetn = 1'b1;
        tick();
        r_hs_cycle();
        expect_val("post_rst_flags", S_FLAGS, 7'h20);
        expect_val("post_rst_valid", S_VALID, 1);
        expect_val("post_rst_out", S_OUT, 0);
        score();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
